// File: rtl/div_method_pkg.sv
// Shared definitions for the div method callee: handshake FSM encoding,
// iteration counter sizing and the divide-by-zero quotient pattern.
package div_method_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_ITER  = 2'd2,
      S_FIX   = 2'd3
   } state_t;

   localparam int MAX_WIDTH = 64;

   localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

   function automatic int cnt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/div_core.sv
// Restoring divider on unsigned magnitudes: start loads operands, each step retires one quotient bit MSB first.
// done is high during the final step; the caller owns all flow control, the core never stalls.
module div_core
   import div_method_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             step,
   input  logic [WIDTH:0]   dividend,
   input  logic [WIDTH:0]   divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done
);

   localparam int CW = cnt_width(WIDTH);

   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH:0]   dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH+1:0] rem_shift;
   logic [WIDTH+1:0] trial;
   logic             keep;

   always_comb begin
      rem_shift = {rem_q, dvd_q[WIDTH-1]};
      trial     = rem_shift - {1'b0, dvs_q};
      keep      = ~trial[WIDTH+1];
      dvd_d     = dvd_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      if (start) begin
         // The magnitude's top bit is always zero, so this clears the partial remainder.
         dvd_d = dividend[WIDTH-1:0];
         rem_d = {{WIDTH{1'b0}}, dividend[WIDTH]};
         dvs_d = divisor;
         cnt_d = CW'(WIDTH - 1);
      end else if (step) begin
         rem_d = keep ? trial[WIDTH:0] : rem_shift[WIDTH:0];
         dvd_d = {dvd_q[WIDTH-2:0], keep};
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dvd_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else begin
         dvd_q <= dvd_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
      end
   end

   assign quotient  = dvd_q;
   assign remainder = rem_q[WIDTH-1:0];
   assign done      = (cnt_q == '0);

endmodule

// File: rtl/div_method_unit.sv
// Divider callee for the req/busy/return method handshake, with a/b/r fields.
// busy lasts WIDTH+2 cycles (2 on divide by zero); req is ignored while busy, nothing is queued.
module div_method_unit
   import div_method_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a_in,
   input  logic             a_we,
   output logic [WIDTH-1:0] a_out,
   input  logic [WIDTH-1:0] b_in,
   input  logic             b_we,
   output logic [WIDTH-1:0] b_out,
   output logic [WIDTH-1:0] r_out,
   input  logic             div_req,
   output logic             div_busy,
   output logic [WIDTH-1:0] div_return
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, ret_q, ret_d;
   logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d, div0_q, div0_d;
   logic [WIDTH:0]   a_ext, b_ext, a_mag, b_mag;
   logic             core_start, core_step, core_done;
   logic [WIDTH-1:0] core_quo, core_rem;

   // Sign-extend one bit so the magnitude of the most negative value is representable.
   always_comb begin
      a_ext = {SIGNED & a_q[WIDTH-1], a_q};
      b_ext = {SIGNED & b_q[WIDTH-1], b_q};
      a_mag = a_ext[WIDTH] ? -a_ext : a_ext;
      b_mag = b_ext[WIDTH] ? -b_ext : b_ext;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         ret_q   <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         ret_q   <= ret_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         div0_q  <= div0_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (div_req) state_d = S_SETUP;
         S_SETUP: state_d = (b_q == '0) ? S_FIX : S_ITER;
         S_ITER:  if (core_done) state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      div_busy   = (state_q != S_IDLE);
      core_start = (state_q == S_SETUP);
      core_step  = (state_q == S_ITER);
   end

   always_comb begin
      a_d     = a_we ? a_in : a_q;
      b_d     = b_we ? b_in : b_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      div0_d  = div0_q;
      ret_d   = ret_q;
      r_d     = r_q;
      if (state_q == S_SETUP) begin
         neg_a_d = a_ext[WIDTH];
         neg_b_d = b_ext[WIDTH];
         div0_d  = (b_q == '0);
      end
      if (state_q == S_FIX) begin
         // On divide by zero the core still holds |a| unshifted, so r restores a.
         if (div0_q) begin
            ret_d = DIV0_QUOTIENT[WIDTH-1:0];
            r_d   = neg_a_q ? -core_quo : core_quo;
         end else begin
            ret_d = (neg_a_q ^ neg_b_q) ? -core_quo : core_quo;
            r_d   = neg_a_q ? -core_rem : core_rem;
         end
      end
   end

   div_core #(.WIDTH(WIDTH)) u_core (
      .clk       (clk),
      .reset     (reset),
      .start     (core_start),
      .step      (core_step),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (core_quo),
      .remainder (core_rem),
      .done      (core_done)
   );

   assign a_out      = a_q;
   assign b_out      = b_q;
   assign r_out      = r_q;
   assign div_return = ret_q;

endmodule

// File: tb/tb_div_method_unit.sv
// Bench for div_method_unit: signed and unsigned instances share stimulus and are checked
// every cycle against a cycle-count/arithmetic model, plus literal expectations per scenario.
module tb_div_method_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [W-1:0]  a_in = '0, b_in = '0;
   logic          a_we = 1'b0, b_we = 1'b0, div_req = 1'b0;

   logic [W-1:0]  s_a_out, s_b_out, s_r_out, s_ret;
   logic          s_busy;
   logic [W-1:0]  u_a_out, u_b_out, u_r_out, u_ret;
   logic          u_busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   div_method_unit #(.WIDTH(W), .SIGNED(1'b1)) u_s (
      .clk(clk), .reset(reset), .a_in(a_in), .a_we(a_we), .a_out(s_a_out),
      .b_in(b_in), .b_we(b_we), .b_out(s_b_out), .r_out(s_r_out),
      .div_req(div_req), .div_busy(s_busy), .div_return(s_ret));

   div_method_unit #(.WIDTH(W), .SIGNED(1'b0)) u_u (
      .clk(clk), .reset(reset), .a_in(a_in), .a_we(a_we), .a_out(u_a_out),
      .b_in(b_in), .b_we(b_we), .b_out(u_b_out), .r_out(u_r_out),
      .div_req(div_req), .div_busy(u_busy), .div_return(u_ret));

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Returns {quotient, remainder} straight from integer arithmetic.
   function automatic logic [63:0] model_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
      longint sa, sb, q, r;
      if (b == '0) return {32'hFFFF_FFFF, a};
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'b0, a});
         sb = longint'({32'b0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {q[31:0], r[31:0]};
   endfunction

   // Model: fields, a busy window whose length is fixed by the divisor seen at the setup edge.
   logic [W-1:0] m_a = '0, m_b = '0;
   logic         m_busy = 1'b0, m_setup = 1'b0;
   int           m_left = 0;
   logic [63:0]  ps = '0, pu = '0;
   logic [W-1:0] ms_ret = '0, ms_r = '0, mu_ret = '0, mu_r = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_a <= '0; m_b <= '0; m_busy <= 1'b0; m_setup <= 1'b0; m_left <= 0;
         ms_ret <= '0; ms_r <= '0; mu_ret <= '0; mu_r <= '0;
      end else begin
         if (a_we) m_a <= a_in;
         if (b_we) m_b <= b_in;
         if (!m_busy) begin
            if (div_req) begin
               m_busy  <= 1'b1;
               m_setup <= 1'b1;
            end
         end else if (m_setup) begin
            m_setup <= 1'b0;
            m_left  <= (m_b == '0) ? 1 : W + 1;
            ps      <= model_div(m_a, m_b, 1'b1);
            pu      <= model_div(m_a, m_b, 1'b0);
         end else if (m_left == 1) begin
            m_busy <= 1'b0;
            m_left <= 0;
            ms_ret <= ps[63:32]; ms_r <= ps[31:0];
            mu_ret <= pu[63:32]; mu_r <= pu[31:0];
         end else begin
            m_left <= m_left - 1;
         end
      end
   end

   always @(negedge clk) begin
      chk("cmp_s_a", s_a_out, m_a);
      chk("cmp_s_b", s_b_out, m_b);
      chk("cmp_s_busy", {31'b0, s_busy}, {31'b0, m_busy});
      chk("cmp_s_ret", s_ret, ms_ret);
      chk("cmp_s_r", s_r_out, ms_r);
      chk("cmp_u_a", u_a_out, m_a);
      chk("cmp_u_b", u_b_out, m_b);
      chk("cmp_u_busy", {31'b0, u_busy}, {31'b0, m_busy});
      chk("cmp_u_ret", u_ret, mu_ret);
      chk("cmp_u_r", u_r_out, mu_r);
   end

   task automatic write_ab(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      a_in = a; b_in = b; a_we = 1'b1; b_we = 1'b1;
      @(negedge clk);
      a_we = 1'b0; b_we = 1'b0;
   endtask

   // Counts busy cycles from the first negedge at which busy is seen high.
   task automatic wait_idle(input string nm, output int n);
      n = 0;
      while (s_busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) chk({nm, "_timeout"}, 32'(n), 32'd0);
   endtask

   task automatic call(input logic [W-1:0] a, input logic [W-1:0] b, input string nm, output int n);
      write_ab(a, b);
      div_req = 1'b1;
      @(negedge clk);
      div_req = 1'b0;
      wait_idle(nm, n);
   endtask

   int n;

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'b0, s_busy}, 32'd0);
      chk("rst_ret", s_ret, 32'd0);
      chk("rst_r", s_r_out, 32'd0);
      chk("rst_a", s_a_out, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      call(32'd100, 32'd7, "c100_7", n);
      chk("len_100_7", 32'(n), 32'd34);
      chk("ret_100_7", s_ret, 32'd14);
      chk("r_100_7", s_r_out, 32'd2);
      chk("u_ret_100_7", u_ret, 32'd14);
      chk("model_q_100_7", ms_ret, 32'd14);
      chk("model_r_100_7", ms_r, 32'd2);

      call(-32'sd100, 32'd7, "cm100_7", n);
      chk("ret_m100_7", s_ret, 32'hFFFF_FFF2);
      chk("r_m100_7", s_r_out, 32'hFFFF_FFFE);
      chk("u_ret_m100_7", u_ret, 32'h2492_4916);
      chk("u_r_m100_7", u_r_out, 32'd2);

      call(32'd100, -32'sd7, "c100_m7", n);
      chk("ret_100_m7", s_ret, 32'hFFFF_FFF2);
      chk("r_100_m7", s_r_out, 32'd2);
      chk("u_ret_100_m7", u_ret, 32'd0);
      chk("u_r_100_m7", u_r_out, 32'd100);

      call(32'h1234, 32'd0, "cdiv0", n);
      chk("len_div0", 32'(n), 32'd2);
      chk("ret_div0", s_ret, 32'hFFFF_FFFF);
      chk("r_div0", s_r_out, 32'h1234);
      chk("u_r_div0", u_r_out, 32'h1234);

      call(32'h8000_0000, 32'hFFFF_FFFF, "cmin", n);
      chk("ret_min_m1", s_ret, 32'h8000_0000);
      chk("r_min_m1", s_r_out, 32'd0);
      chk("u_ret_min", u_ret, 32'd0);
      chk("u_r_min", u_r_out, 32'h8000_0000);
      chk("model_min", ms_ret, 32'h8000_0000);

      // Reset during the tenth ITER cycle.
      write_ab(32'd1000, 32'd3);
      div_req = 1'b1;
      @(negedge clk);
      div_req = 1'b0;
      repeat (10) @(negedge clk);
      chk("mid_busy_before", {31'b0, s_busy}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_busy", {31'b0, s_busy}, 32'd0);
      chk("mid_rst_ret", s_ret, 32'd0);
      chk("mid_rst_r", s_r_out, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      call(32'd1000, 32'd33, "c_after_rst", n);
      chk("after_rst_ret", s_ret, 32'd30);
      chk("after_rst_r", s_r_out, 32'd10);

      // Back-to-back calls with req held; a rewritten mid-call.
      write_ab(32'd50, 32'd5);
      div_req = 1'b1;
      @(negedge clk);
      a_in = 32'd9; a_we = 1'b1;
      @(negedge clk);
      a_we = 1'b0;
      wait_idle("b2b_first", n);
      chk("b2b_ret1", s_ret, 32'd10);
      chk("b2b_r1", s_r_out, 32'd0);
      chk("b2b_gap", {31'b0, s_busy}, 32'd0);
      @(negedge clk);
      chk("b2b_restart", {31'b0, s_busy}, 32'd1);
      div_req = 1'b0;
      wait_idle("b2b_second", n);
      chk("b2b_ret2", s_ret, 32'd1);
      chk("b2b_r2", s_r_out, 32'd4);
      repeat (3) @(negedge clk);
      chk("b2b_no_third", {31'b0, s_busy}, 32'd0);

      // req pulses while busy must not queue another call.
      write_ab(32'd77, 32'd7);
      div_req = 1'b1;
      @(negedge clk);
      div_req = 1'b0;
      repeat (5) @(negedge clk);
      div_req = 1'b1;
      @(negedge clk);
      div_req = 1'b0;
      wait_idle("pulse", n);
      chk("pulse_ret", s_ret, 32'd11);
      repeat (3) @(negedge clk);
      chk("pulse_no_extra", {31'b0, s_busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
